// File: rtl/dq_min_search.sv
// dq_min_search
// Scans one frame of NUM_Q candidates and keeps the one with the smallest
// signed metric dq, together with its q index and four symbol indices.
// It also flags any q index that appears twice within the same frame.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start                pulse that opens (or, mid-frame, restarts) a frame
//   cand_valid           candidate present on cand_q / dq_in / sym_* this cycle
//   cand_q               q index of the candidate
//   dq_in                signed metric of the candidate, stored bit-exact
//   sym_I1..sym_Q2       symbol indices of the candidate
//   in_ready, busy       high only while a frame is being collected
//   done                 one-cycle pulse, frame result valid
//   best_q, best_dq      index and metric of the minimum-dq candidate
//   best_I1..best_Q2     symbol indices of the winning candidate
//   dup_err              sticky, a q index was repeated in the current frame
module dq_min_search #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int NUM_Q = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         cand_valid,
  input  logic [3:0]   cand_q,
  input  logic [N-1:0] dq_in,
  input  logic [2:0]   sym_I1,
  input  logic [2:0]   sym_Q1,
  input  logic [2:0]   sym_I2,
  input  logic [2:0]   sym_Q2,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic [3:0]   best_q,
  output logic [N-1:0] best_dq,
  output logic [2:0]   best_I1,
  output logic [2:0]   best_Q1,
  output logic [2:0]   best_I2,
  output logic [2:0]   best_Q2,
  output logic         dup_err
);

  localparam int CW = $clog2(NUM_Q) + 1;
  localparam logic [N-1:0] DQ_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_Q - 1);

  // Q only documents the fixed-point format of dq; the search is a plain
  // signed compare, so nothing is generated from it.
  if (Q > N) begin : g_q_exceeds_width
  end

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [15:0]    seen;

  // Single control/datapath register block.
  // The first accepted candidate of a frame is always taken as the current
  // best. This makes a frame in which every dq equals the most-positive value
  // report the first candidate, not stale data. After that, only a strictly
  // smaller dq replaces the best, so on a tie the earlier candidate wins.
  // A start in COLLECT re-initialises the frame and takes priority over a
  // candidate that arrives in the same cycle, so that candidate is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      seen     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      best_q   <= '0;
      best_dq  <= '0;
      best_I1  <= '0;
      best_Q1  <= '0;
      best_I2  <= '0;
      best_Q2  <= '0;
      dup_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            count    <= '0;
            seen     <= '0;
            dup_err  <= 1'b0;
            best_dq  <= DQ_MAX;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (start) begin
            count   <= '0;
            seen    <= '0;
            dup_err <= 1'b0;
            best_dq <= DQ_MAX;
          end else if (cand_valid) begin
            count        <= count + 1'b1;
            seen[cand_q] <= 1'b1;
            if (seen[cand_q]) begin
              dup_err <= 1'b1;
            end
            if ((count == '0) || ($signed(dq_in) < $signed(best_dq))) begin
              best_q  <= cand_q;
              best_dq <= dq_in;
              best_I1 <= sym_I1;
              best_Q1 <= sym_Q1;
              best_I2 <= sym_I2;
              best_Q2 <= sym_Q2;
            end
            if (count == LAST_IDX) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dq_min_search.sv
// tb_dq_min_search
// Self-checking bench for dq_min_search. Each full frame pushes its expected
// result, computed from the stimulus by a small reference model, onto a
// scoreboard queue. A monitor pops and compares one entry on every done pulse.
module tb_dq_min_search;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        cand_valid;
  logic [3:0]  cand_q;
  logic [31:0] dq_in;
  logic [2:0]  sym_I1, sym_Q1, sym_I2, sym_Q2;
  logic        in_ready, busy, done, dup_err;
  logic [3:0]  best_q;
  logic [31:0] best_dq;
  logic [2:0]  best_I1, best_Q1, best_I2, best_Q2;

  typedef struct packed {
    logic [3:0]  q;
    logic [31:0] dq;
    logic [11:0] sym;
  } cand_t;

  typedef struct packed {
    logic [3:0]  q;
    logic [31:0] dq;
    logic [11:0] sym;
    logic        dup;
  } exp_t;

  cand_t frame [16];
  exp_t  sb_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  cand_t idle_c = '0;

  dq_min_search #(.N(32), .Q(16), .NUM_Q(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cand_valid(cand_valid),
    .cand_q(cand_q), .dq_in(dq_in),
    .sym_I1(sym_I1), .sym_Q1(sym_Q1), .sym_I2(sym_I2), .sym_Q2(sym_Q2),
    .in_ready(in_ready), .busy(busy), .done(done),
    .best_q(best_q), .best_dq(best_dq),
    .best_I1(best_I1), .best_Q1(best_Q1), .best_I2(best_I2), .best_Q2(best_Q2),
    .dup_err(dup_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single point of comparison: counts and reports
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one set of inputs and consume one rising edge
  task automatic drive(input logic s, input logic v, input cand_t c);
    start      = s;
    cand_valid = v;
    cand_q     = c.q;
    dq_in      = c.dq;
    {sym_I1, sym_Q1, sym_I2, sym_Q2} = c.sym;
    @(posedge clk);
    #1;
  endtask

  // Reference model: first minimum wins, duplicate detection over q
  function automatic exp_t model_frame();
    exp_t        e;
    int          b;
    logic [15:0] s;
    b = 0;
    s = '0;
    e.dup = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && $signed(frame[i].dq) < $signed(frame[b].dq)) b = i;
      if (s[frame[i].q]) e.dup = 1'b1;
      s[frame[i].q] = 1'b1;
    end
    e.q   = frame[b].q;
    e.dq  = frame[b].dq;
    e.sym = frame[b].sym;
    return e;
  endfunction

  // Run one 16-candidate frame, optionally opening it with start and
  // optionally inserting idle cycles between candidates
  task automatic apply_stimulus(input bit do_start, input bit gaps);
    sb_q.push_back(model_frame());
    if (do_start) begin
      drive(1'b1, 1'b0, idle_c);
      @(negedge clk);
      check_output("in_ready_collect", 64'(in_ready), 64'd1);
      check_output("dup_clear_on_start", 64'(dup_err), 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 4 == 2)) begin
        drive(1'b0, 1'b0, idle_c);
        drive(1'b0, 1'b0, idle_c);
      end
      drive(1'b0, 1'b1, frame[i]);
    end
    start      = 1'b0;
    cand_valid = 1'b0;
    @(negedge clk);
    check_output("done_latency", 64'(done), 64'd1);
    @(negedge clk);
    check_output("done_width", 64'(done), 64'd0);
    check_output("busy_after", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: compare a result on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_output("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_output("best_q", 64'(best_q), 64'(e.q));
        check_output("best_dq", 64'(best_dq), 64'(e.dq));
        check_output("best_sym", 64'({best_I1, best_Q1, best_I2, best_Q2}), 64'(e.sym));
        check_output("dup_err", 64'(dup_err), 64'(e.dup));
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    cand_valid = 1'b0;
    cand_q = '0;
    dq_in = '0;
    {sym_I1, sym_Q1, sym_I2, sym_Q2} = '0;
    #3;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_best_dq", 64'(best_dq), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b0, 1'b0, idle_c);

    // Normal frame: dq = 100 - 5q, q=7 has dq=2
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = 4'(i);
      frame[i].dq  = (i == 7) ? 32'd2 : 32'(100 - i * 5);
      frame[i].sym = 12'(i * 37 + 5);
    end
    apply_stimulus(1'b1, 1'b0);

    // Tie with gaps: q=3 and q=9 both hold the minimum 10
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = 4'(i);
      frame[i].dq  = (i == 3 || i == 9) ? 32'd10 : 32'(50 + i);
      frame[i].sym = 12'(i * 91 + 3);
    end
    apply_stimulus(1'b1, 1'b1);

    // Negative and most-positive values
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = 4'(15 - i);
      frame[i].dq  = 32'(1000 + i);
      frame[i].sym = 12'(i * 53 + 11);
    end
    frame[4].dq  = 32'hFFFF_FFFF;
    frame[10].dq = 32'h7FFF_FFFF;
    apply_stimulus(1'b1, 1'b0);

    // All most-positive: first accepted candidate wins
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = 4'((i + 6) % 16);
      frame[i].dq  = 32'h7FFF_FFFF;
      frame[i].sym = 12'(i * 29 + 7);
    end
    apply_stimulus(1'b1, 1'b0);

    // Duplicate: q=5 twice, q=15 missing
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = (i == 15) ? 4'd5 : 4'(i);
      frame[i].dq  = $urandom_range(2000, 0) - 1000;
      frame[i].sym = 12'($urandom);
    end
    apply_stimulus(1'b1, 1'b0);
    drive(1'b0, 1'b0, idle_c);
    drive(1'b0, 1'b0, idle_c);
    check_output("dup_held", 64'(dup_err), 64'd1);

    // Abort after 8 candidates, then start coinciding with a candidate
    for (int i = 0; i < 8; i++) begin
      frame[i].q   = 4'(i);
      frame[i].dq  = 32'(-500 - i);
      frame[i].sym = 12'hFFF;
    end
    drive(1'b1, 1'b0, idle_c);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, frame[i]);
    drive(1'b1, 1'b1, '{q: 4'd0, dq: 32'hFFFF_0000, sym: 12'hABC});
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = 4'(i);
      frame[i].dq  = 32'(300 - ((i * 7) % 16) * 3);
      frame[i].sym = 12'(i * 61 + 2);
    end
    apply_stimulus(1'b0, 1'b0);

    // Reset mid-frame after 5 candidates
    drive(1'b1, 1'b0, idle_c);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, '{q: 4'(i), dq: 32'(i + 1), sym: 12'(i + 1)});
    rstn = 1'b0;
    #2;
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_in_ready", 64'(in_ready), 64'd0);
    check_output("midrst_best_q", 64'(best_q), 64'd0);
    check_output("midrst_best_dq", 64'(best_dq), 64'd0);
    check_output("midrst_best_sym", 64'({best_I1, best_Q1, best_I2, best_Q2}), 64'd0);
    check_output("midrst_dup_err", 64'(dup_err), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Candidates before any start must be ignored
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '{q: 4'(i), dq: 32'hFFFF_F000, sym: 12'h777});
    cand_valid = 1'b0;
    @(negedge clk);
    check_output("idle_ignore_dq", 64'(best_dq), 64'd0);
    check_output("idle_in_ready", 64'(in_ready), 64'd0);

    // Random frame after reset
    for (int i = 0; i < 16; i++) begin
      frame[i].q   = 4'(i);
      frame[i].dq  = $urandom;
      frame[i].sym = 12'($urandom);
    end
    apply_stimulus(1'b1, 1'b1);

    repeat (3) @(negedge clk);
    check_output("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
